// File: rtl/ariane_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : ariane_pkg                                                    |
// | Description: RoCC command/response types, data widths and dispatch states. |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package ariane_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;

    typedef struct packed {
        logic [6:0]      funct;
        logic [4:0]      rs2;
        logic [4:0]      rs1;
        logic            xd;
        logic            xs1;
        logic            xs2;
        logic [RD_W-1:0] rd;
        logic [6:0]      opcode;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } rocc_cmd_t;

    typedef struct packed {
        logic [RD_W-1:0] resp_rd;
        logic [XLEN-1:0] resp_data;
    } rocc_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } disp_state_e;

    localparam int unsigned ROCC_CMD_W = $bits(rocc_cmd_t);

endpackage
`default_nettype wire

// File: rtl/rocc_dispatch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : rocc_dispatch_if                                              |
// | Description: Core, accelerator and writeback handshakes of rocc_dispatch.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface rocc_dispatch_if;
    import ariane_pkg::*;

    rocc_cmd_t        core_cmd_i;
    logic             core_cmd_valid_i;
    logic             core_cmd_ready_o;

    rocc_cmd_t        rocc_cmd_o;
    logic             rocc_cmd_valid_o;
    logic             rocc_cmd_ready_i;

    rocc_resp_t       rocc_resp_i;
    logic             rocc_resp_valid_i;
    logic             rocc_resp_ready_o;

    logic [RD_W-1:0]  wb_rd_o;
    logic [XLEN-1:0]  wb_data_o;
    logic             wb_valid_o;
    logic             wb_ready_i;

    // The dispatcher itself
    modport slave (
        input  core_cmd_i, core_cmd_valid_i, rocc_cmd_ready_i,
        input  rocc_resp_i, rocc_resp_valid_i, wb_ready_i,
        output core_cmd_ready_o, rocc_cmd_o, rocc_cmd_valid_o,
        output rocc_resp_ready_o, wb_rd_o, wb_data_o, wb_valid_o
    );

    // Core plus accelerator environment around the dispatcher
    modport master (
        output core_cmd_i, core_cmd_valid_i, rocc_cmd_ready_i,
        output rocc_resp_i, rocc_resp_valid_i, wb_ready_i,
        input  core_cmd_ready_o, rocc_cmd_o, rocc_cmd_valid_o,
        input  rocc_resp_ready_o, wb_rd_o, wb_data_o, wb_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/rocc_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rocc_cmd_fifo                                                 |
// | Description: Synchronous FIFO with clear; push while full allowed on pop.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module rocc_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Wrap explicitly so depths that are not a power of two also work
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rocc_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rocc_dispatch                                                 |
// | Description: Buffers RoCC commands, limits outstanding xd commands and     |
// |              returns responses through a one-entry writeback register.     |
// |              Define ROCC_RESP_CHECK_EN to enable response rd order check.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module rocc_dispatch
    import ariane_pkg::*;
#(
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  wire logic                                   clk_i,
    input  wire logic                                   rst_ni,
    input  wire logic                                   flush_i,
    rocc_dispatch_if.slave                              bus,
    output logic                                        busy_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding_o,
    output logic                                        rd_mismatch_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    disp_state_e      r_state;
    disp_state_e      w_state_nxt;

    rocc_cmd_t        w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_clear;
    logic             w_at_max;
    logic             w_issue_xd;
    logic             w_resp_acc;
    logic             w_resp_live;
    logic             w_wb_drain;

    logic [OUT_W-1:0] r_outstanding;
    logic             r_wb_valid;
    logic [RD_W-1:0]  r_wb_rd;
    logic [XLEN-1:0]  r_wb_data;

    assign w_clear = (r_state == ST_ACTIVE) & flush_i;

    rocc_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (ROCC_CMD_W)
    ) u_cmd_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .i_clear (w_clear),
        .i_push  (w_push & ~w_clear),
        .i_pop   (w_pop & ~w_clear),
        .i_data  (bus.core_cmd_i),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_at_max             = (r_outstanding == OUT_W'(MAX_OUTSTANDING));
    assign bus.rocc_cmd_o       = w_head;
    assign bus.rocc_cmd_valid_o = ~w_fifo_empty & ~(w_head.xd & w_at_max);
    assign w_pop                = bus.rocc_cmd_valid_o & bus.rocc_cmd_ready_i;
    assign bus.core_cmd_ready_o = (r_state == ST_ACTIVE) & (~w_fifo_full | w_pop);
    assign w_push               = bus.core_cmd_valid_i & bus.core_cmd_ready_o;
    assign w_issue_xd           = w_pop & w_head.xd;

    // Gated by state so the handshake reads 0 while held in reset
    assign bus.rocc_resp_ready_o = (r_state != ST_IDLE) & (~r_wb_valid | bus.wb_ready_i);
    assign w_resp_acc            = bus.rocc_resp_valid_i & bus.rocc_resp_ready_o;
    assign w_resp_live           = w_resp_acc & (r_outstanding != '0);
    assign w_wb_drain            = r_wb_valid & bus.wb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issue_xd, w_resp_live})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else if (w_resp_live) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= bus.rocc_resp_i.resp_rd;
            r_wb_data  <= bus.rocc_resp_i.resp_data;
        end else if (w_wb_drain) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign bus.wb_valid_o = r_wb_valid;
    assign bus.wb_rd_o    = r_wb_rd;
    assign bus.wb_data_o  = r_wb_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (!flush_i) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (flush_i)  w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if ((r_outstanding == '0) && !r_wb_valid) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o        = (r_state != ST_IDLE);
    assign outstanding_o = r_outstanding;

`ifdef ROCC_RESP_CHECK_EN
    logic [RD_W-1:0] w_exp_rd;
    logic            w_rdq_full;
    logic            w_rdq_empty;
    logic            r_rd_mismatch;

    // Holds rd of each in-flight xd command, oldest first
    rocc_cmd_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (RD_W)
    ) u_rd_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .i_clear (1'b0),
        .i_push  (w_issue_xd),
        .i_pop   (w_resp_live),
        .i_data  (w_head.rd),
        .o_data  (w_exp_rd),
        .o_full  (w_rdq_full),
        .o_empty (w_rdq_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_mismatch <= 1'b0;
        end else if (w_resp_acc && (!w_resp_live || w_rdq_empty ||
                     (bus.rocc_resp_i.resp_rd != w_exp_rd) ||
                     (w_rdq_full && w_issue_xd && !w_resp_live))) begin
            r_rd_mismatch <= 1'b1;
        end
    end

    assign rd_mismatch_o = r_rd_mismatch;
`else
    assign rd_mismatch_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rocc_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_rocc_dispatch                                              |
// | Description: Self-checking bench for rocc_dispatch against a queue model.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_rocc_dispatch;
    import ariane_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 4;
    localparam int OW    = $clog2(MAXO + 1);
    localparam int S_IDLE = 0, S_ACT = 1, S_DRN = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          busy;
    logic [OW-1:0] outs;
    logic          mism;

    rocc_dispatch_if bus();

    rocc_dispatch #(.CMD_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus),
        .busy_o(busy), .outstanding_o(outs), .rd_mismatch_o(mism)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: plain queues and counters
    rocc_cmd_t   mq[$];
    logic [4:0]  m_rdq[$];
    int          m_outs;
    int          m_st;
    logic        m_wbv;
    logic [4:0]  m_wbrd;
    logic [63:0] m_wbd;
    logic        m_mis;
    logic        e_cvalid, e_pop, e_cready, e_rready;

    function automatic void model_reset();
        mq.delete(); m_rdq.delete();
        m_outs = 0; m_st = S_IDLE; m_wbv = 0; m_wbrd = '0; m_wbd = '0; m_mis = 0;
    endfunction

    function automatic void predict();
        e_cvalid = (mq.size() > 0) && !(mq[0].xd && m_outs == MAXO);
        e_pop    = e_cvalid && bus.rocc_cmd_ready_i;
        e_cready = (m_st == S_ACT) && (mq.size() < DEPTH || e_pop);
        e_rready = (m_st != S_IDLE) && (!m_wbv || bus.wb_ready_i);
    endfunction

    function automatic void model_clock();
        bit        push, resp, live, fl, wbv0;
        int        outs0;
        rocc_cmd_t head;
        push  = bus.core_cmd_valid_i && e_cready;
        resp  = bus.rocc_resp_valid_i && e_rready;
        live  = resp && (m_outs > 0);
        fl    = (m_st == S_ACT) && flush;
        outs0 = m_outs;
        wbv0  = m_wbv;
        head  = '0;
        if (e_pop) head = mq[0];
        if (live) begin
            m_outs--;
            if (m_rdq.pop_front() != bus.rocc_resp_i.resp_rd) m_mis = 1;
        end
        if (e_pop && head.xd) begin
            m_outs++;
            m_rdq.push_back(head.rd);
        end
        if (resp && !live) m_mis = 1;
        if (m_wbv && bus.wb_ready_i) m_wbv = 0;
        if (live) begin
            m_wbv = 1; m_wbrd = bus.rocc_resp_i.resp_rd; m_wbd = bus.rocc_resp_i.resp_data;
        end
        if (fl) mq.delete();
        else begin
            if (e_pop) void'(mq.pop_front());
            if (push)  mq.push_back(bus.core_cmd_i);
        end
        case (m_st)
            S_IDLE:  if (!flush) m_st = S_ACT;
            S_ACT:   if (flush)  m_st = S_DRN;
            default: if (outs0 == 0 && !wbv0) m_st = S_IDLE;
        endcase
`ifndef ROCC_RESP_CHECK_EN
        m_mis = 0;
`endif
    endfunction

    function automatic rocc_cmd_t mk_cmd(input bit xd, input logic [4:0] rd);
        rocc_cmd_t c;
        c.funct = 7'($urandom); c.rs2 = 5'($urandom); c.rs1 = 5'($urandom);
        c.xs1 = 1'($urandom); c.xs2 = 1'($urandom); c.opcode = 7'($urandom);
        c.rs1_data = {$urandom, $urandom}; c.rs2_data = {$urandom, $urandom};
        c.xd = xd; c.rd = rd;
        return c;
    endfunction

    task automatic idle_inputs();
        bus.core_cmd_i = '0; bus.core_cmd_valid_i = 0; bus.rocc_cmd_ready_i = 0;
        bus.rocc_resp_i = '0; bus.rocc_resp_valid_i = 0; bus.wb_ready_i = 0; flush = 0;
    endtask

    task automatic settle();
        #1; predict();
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if ({busy, outs, mism, bus.rocc_cmd_valid_o, bus.core_cmd_ready_o, bus.rocc_resp_ready_o,
             bus.wb_valid_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b busy/outs/mism/cv/cr/rr/wv, want all 0",
                     {busy, outs, mism, bus.rocc_cmd_valid_o, bus.core_cmd_ready_o,
                      bus.rocc_resp_ready_o, bus.wb_valid_o});
        end
        vectors++;
        if ({bus.wb_rd_o, bus.wb_data_o, bus.rocc_cmd_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: wb_rd=%h wb_data=%h cmd=%h, want 0",
                     bus.wb_rd_o, bus.wb_data_o, bus.rocc_cmd_o);
        end
        @(negedge clk);
        rst_n = 1;
        settle();
        vectors++;
        if (busy !== 1'b0 || bus.core_cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b core_ready=%b, want 0 0", busy, bus.core_cmd_ready_o);
        end
        tick();
        settle();
        vectors++;
        if (busy !== 1'b1 || bus.core_cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_active: busy=%b core_ready=%b, want 1 1", busy, bus.core_cmd_ready_o);
        end
    endtask

    task automatic test_fifo_full();
        rocc_cmd_t sent[4];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.core_cmd_valid_i = 1;
            bus.core_cmd_i = mk_cmd(0, 5'(i));
            if (i < 4) sent[i] = bus.core_cmd_i;
            settle();
            vectors++;
            if (bus.core_cmd_ready_o !== (i < 4)) begin
                errors++;
                $display("FAIL fifo_full_ready[%0d]: got %b want %b", i, bus.core_cmd_ready_o, i < 4);
            end
            tick();
        end
        bus.core_cmd_valid_i = 0;
        bus.rocc_cmd_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            vectors++;
            if (bus.rocc_cmd_valid_o !== 1'b1 || bus.rocc_cmd_o !== sent[i]) begin
                errors++;
                $display("FAIL fifo_order[%0d]: valid=%b cmd=%h want 1 %h",
                         i, bus.rocc_cmd_valid_o, bus.rocc_cmd_o, sent[i]);
            end
            tick();
        end
        settle();
        vectors++;
        if (bus.rocc_cmd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: valid=%b want 0", bus.rocc_cmd_valid_o);
        end
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        bus.rocc_cmd_ready_i = 1;
        bus.wb_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.core_cmd_valid_i = 1;
            bus.core_cmd_i = mk_cmd(1, 5'(i + 1));
            tick();
        end
        bus.core_cmd_valid_i = 0;
        repeat (2) tick();
        settle();
        vectors++;
        if (bus.rocc_cmd_valid_o !== 1'b0 || outs !== OW'(4)) begin
            errors++;
            $display("FAIL outs_hold: valid=%b outs=%0d want 0 4", bus.rocc_cmd_valid_o, outs);
        end
        bus.rocc_resp_valid_i = 1;
        bus.rocc_resp_i = '{resp_rd: 5'd1, resp_data: 64'h1};
        tick();
        bus.rocc_resp_valid_i = 0;
        settle();
        vectors++;
        if (bus.rocc_cmd_valid_o !== 1'b1 || outs !== OW'(3)) begin
            errors++;
            $display("FAIL outs_release: valid=%b outs=%0d want 1 3", bus.rocc_cmd_valid_o, outs);
        end
        tick();
        settle();
        vectors++;
        if (bus.rocc_cmd_valid_o !== 1'b0 || outs !== OW'(4)) begin
            errors++;
            $display("FAIL outs_refill: valid=%b outs=%0d want 0 4", bus.rocc_cmd_valid_o, outs);
        end
        for (int i = 2; i <= 5; i++) begin
            bus.rocc_resp_valid_i = 1;
            bus.rocc_resp_i = '{resp_rd: 5'(i), resp_data: 64'(i)};
            tick();
        end
        bus.rocc_resp_valid_i = 0;
        settle();
        vectors++;
        if (outs !== OW'(0) || mism !== 1'b0) begin
            errors++;
            $display("FAIL outs_empty: outs=%0d mism=%b want 0 0", outs, mism);
        end
    endtask

    task automatic test_wb_backpressure();
        do_reset();
        bus.rocc_cmd_ready_i = 1;
        bus.core_cmd_valid_i = 1;
        bus.core_cmd_i = mk_cmd(1, 5'd9);
        tick();
        bus.core_cmd_valid_i = 0;
        tick();
        bus.rocc_resp_valid_i = 1;
        bus.rocc_resp_i = '{resp_rd: 5'd9, resp_data: 64'hcccccccccccccccc};
        settle();
        vectors++;
        if (bus.rocc_resp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wb_first_ready: got %b want 1", bus.rocc_resp_ready_o);
        end
        tick();
        bus.rocc_resp_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_rd_o !== 5'd9 ||
                bus.wb_data_o !== 64'hcccccccccccccccc || bus.rocc_resp_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL wb_hold[%0d]: v=%b rd=%0d d=%h rr=%b want 1 9 cccccccccccccccc 0",
                         i, bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, bus.rocc_resp_ready_o);
            end
            tick();
        end
        bus.wb_ready_i = 1;
        settle();
        vectors++;
        if (bus.rocc_resp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wb_release_ready: got %b want 1", bus.rocc_resp_ready_o);
        end
        tick();
        settle();
        vectors++;
        if (bus.wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wb_drained: got %b want 0", bus.wb_valid_o);
        end
    endtask

    task automatic test_flush();
        int exp_busy[4] = '{1, 1, 0, 1};
        do_reset();
        bus.core_cmd_valid_i = 1;
        bus.core_cmd_i = mk_cmd(1, 5'd7);
        tick();
        bus.rocc_cmd_ready_i = 1;
        bus.core_cmd_i = mk_cmd(0, 5'd1);
        tick();
        bus.rocc_cmd_ready_i = 0;
        bus.core_cmd_i = mk_cmd(0, 5'd2);
        tick();
        bus.core_cmd_valid_i = 0;
        settle();
        vectors++;
        if (outs !== OW'(1) || bus.rocc_cmd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: outs=%0d valid=%b want 1 1", outs, bus.rocc_cmd_valid_o);
        end
        flush = 1;
        tick();
        flush = 0;
        bus.core_cmd_valid_i = 1;
        settle();
        vectors++;
        if (bus.rocc_cmd_valid_o !== 1'b0 || busy !== 1'b1 || bus.core_cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: valid=%b busy=%b core_ready=%b want 0 1 0",
                     bus.rocc_cmd_valid_o, busy, bus.core_cmd_ready_o);
        end
        tick();
        bus.core_cmd_valid_i = 0;
        bus.wb_ready_i = 1;
        bus.rocc_resp_valid_i = 1;
        bus.rocc_resp_i = '{resp_rd: 5'd7, resp_data: 64'h77};
        tick();
        bus.rocc_resp_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            vectors++;
            if (busy !== 1'(exp_busy[i])) begin
                errors++;
                $display("FAIL flush_busy[%0d]: got %b want %0d", i, busy, exp_busy[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4:0] rd;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.core_cmd_valid_i  = ($urandom_range(0, 9) < 7);
            bus.core_cmd_i        = mk_cmd(1'($urandom), 5'($urandom));
            bus.rocc_cmd_ready_i  = ($urandom_range(0, 9) < 6);
            bus.wb_ready_i        = ($urandom_range(0, 9) < 7);
            bus.rocc_resp_valid_i = ($urandom_range(0, 9) < 4);
            rd = 5'($urandom);
            if (m_rdq.size() > 0 && $urandom_range(0, 7) != 0) rd = m_rdq[0];
            bus.rocc_resp_i = '{resp_rd: rd, resp_data: {$urandom, $urandom}};
            flush = ($urandom_range(0, 49) == 0);
            if (flush) bus.rocc_cmd_ready_i = 0;
            settle();
            vectors++;
            if (bus.rocc_cmd_valid_o !== e_cvalid || (e_cvalid && bus.rocc_cmd_o !== mq[0])) begin
                errors++;
                $display("FAIL rnd_cmd@%0d: valid=%b cmd=%h want valid %b", cyc,
                         bus.rocc_cmd_valid_o, bus.rocc_cmd_o, e_cvalid);
            end
            vectors++;
            if (bus.core_cmd_ready_o !== e_cready || bus.rocc_resp_ready_o !== e_rready) begin
                errors++;
                $display("FAIL rnd_ready@%0d: core=%b resp=%b want %b %b", cyc,
                         bus.core_cmd_ready_o, bus.rocc_resp_ready_o, e_cready, e_rready);
            end
            vectors++;
            if (bus.wb_valid_o !== m_wbv || (m_wbv && {bus.wb_rd_o, bus.wb_data_o} !== {m_wbrd, m_wbd})) begin
                errors++;
                $display("FAIL rnd_wb@%0d: v=%b rd=%0d d=%h want %b %0d %h", cyc,
                         bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, m_wbv, m_wbrd, m_wbd);
            end
            vectors++;
            if (busy !== (m_st != S_IDLE) || outs !== OW'(m_outs) || mism !== m_mis) begin
                errors++;
                $display("FAIL rnd_status@%0d: busy=%b outs=%0d mism=%b want %b %0d %b", cyc,
                         busy, outs, mism, m_st != S_IDLE, m_outs, m_mis);
            end
            tick();
        end
        idle_inputs();
    endtask

`ifdef ROCC_RESP_CHECK_EN
    task automatic test_rd_mismatch();
        do_reset();
        bus.rocc_cmd_ready_i = 1;
        bus.wb_ready_i = 1;
        bus.core_cmd_valid_i = 1;
        bus.core_cmd_i = mk_cmd(1, 5'd5);
        tick();
        bus.core_cmd_valid_i = 0;
        tick();
        bus.rocc_resp_valid_i = 1;
        bus.rocc_resp_i = '{resp_rd: 5'd9, resp_data: 64'h9};
        tick();
        bus.rocc_resp_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            vectors++;
            if (mism !== 1'b1) begin
                errors++;
                $display("FAIL rd_mismatch_sticky[%0d]: got %b want 1", i, mism);
            end
            tick();
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if (mism !== 1'b0) begin
            errors++;
            $display("FAIL rd_mismatch_reset: got %b want 0", mism);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        bus.rocc_cmd_ready_i = 1;
        bus.wb_ready_i = 0;
        for (int i = 0; i < 6; i++) begin
            bus.core_cmd_valid_i = 1;
            bus.core_cmd_i = mk_cmd(1'(i & 1), 5'(i + 1));
            bus.rocc_resp_valid_i = (i == 3);
            bus.rocc_resp_i = '{resp_rd: 5'd2, resp_data: 64'hdead};
            tick();
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({busy, outs, mism, bus.rocc_cmd_valid_o, bus.core_cmd_ready_o, bus.rocc_resp_ready_o,
             bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, bus.rocc_cmd_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b outs=%0d cv=%b cr=%b rr=%b wv=%b wd=%h, want all 0",
                     busy, outs, bus.rocc_cmd_valid_o, bus.core_cmd_ready_o,
                     bus.rocc_resp_ready_o, bus.wb_valid_o, bus.wb_data_o);
        end
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fifo_full();
        test_outstanding_limit();
        test_wb_backpressure();
        test_flush();
        test_random();
`ifdef ROCC_RESP_CHECK_EN
        test_rd_mismatch();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
